// File: rtl/i2c_multi_avalon_bridge.sv
// Avalon-MM front end that time-shares one i2c_master core across several open-drain buses.
// It also provides a read FIFO for received words, a transaction watchdog, and a per-channel bus-recovery sequencer.
`timescale 1ns/1ps
module i2c_multi_avalon_bridge #(
    parameter int NUM_CHANNELS         = 4,
    parameter int FIFO_DEPTH           = 16,
    parameter int RECOVERY_PULSES      = 9,
    parameter int RECOVERY_HALF_CYCLES = 250,
    parameter int TIMEOUT_CYCLES       = 5_000_000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic                    waitrequest,
    inout  wire  [NUM_CHANNELS-1:0] scl,
    inout  wire  [NUM_CHANNELS-1:0] sda,
    output logic                    m_ena,
    output logic [6:0]              m_addr,
    output logic                    m_rw,
    output logic [31:0]             m_data_wr,
    output logic                    m_read_only,
    output logic [7:0]              m_number_of_bytes,
    input  logic                    m_busy,
    input  logic [31:0]             m_data_rd,
    input  logic                    m_ack_error,
    input  logic [7:0]              m_byte_counter,
    input  logic                    m_fifo_write_ack,
    input  logic                    m_scl_low,
    input  logic                    m_sda_low,
    output logic                    m_scl_in,
    output logic                    m_sda_in
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;
    localparam logic [UW-1:0] FULL_CNT  = UW'(FIFO_DEPTH);
    localparam logic [31:0]   WD_LOAD   = 32'(TIMEOUT_CYCLES);
    localparam logic [15:0]   HALF_LAST = 16'(RECOVERY_HALF_CYCLES - 1);
    localparam logic [7:0]    IDX_PULSE = 8'(2 * RECOVERY_PULSES);
    localparam logic [7:0]    IDX_STOP  = 8'(2 * RECOVERY_PULSES + 1);
    localparam logic [7:0]    IDX_LAST  = 8'(2 * RECOVERY_PULSES + 3);

    logic [2:0]    state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          rw_q, rw_d, ro_q, ro_d;
    logic [7:0]    nbytes_q, nbytes_d;
    logic [2:0]    chan_q, chan_d;
    logic          ack_err_q, ack_err_d, timeout_q, timeout_d, ovf_q, ovf_d;
    logic [31:0]   wd_q, wd_d;
    logic [15:0]   half_cnt_q, half_cnt_d;
    logic [7:0]    half_idx_q, half_idx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0] usedw_q, usedw_d;
    logic          fack_q;
    logic [31:0]   mem [FIFO_DEPTH];

    logic wr_en, push, pop, full, fifo_we, fifo_clr;
    logic rec_scl_low, rec_sda_low, drv_scl_low, drv_sda_low, core_owns;

    assign full  = (usedw_q == FULL_CNT);
    assign push  = m_fifo_write_ack && !fack_q;
    assign pop   = read && (address == 4'd1) && (usedw_q != '0);
    assign wr_en = write && (state_q == S_IDLE);

    // NOTE: every next-state signal takes its default first so the block stays purely combinational.
    always_comb begin
        state_d    = state_q;    addr_d     = addr_q;     data_d    = data_q;
        rw_d       = rw_q;       ro_d       = ro_q;       nbytes_d  = nbytes_q;
        chan_d     = chan_q;     ack_err_d  = ack_err_q;  timeout_d = timeout_q;
        ovf_d      = ovf_q;      wd_d       = wd_q;
        half_cnt_d = half_cnt_q; half_idx_d = half_idx_q;
        wr_ptr_d   = wr_ptr_q;   rd_ptr_d   = rd_ptr_q;   usedw_d   = usedw_q;
        fifo_clr   = 1'b0;
        fifo_we    = 1'b0;

        if (wr_en) begin
            case (address)
                4'd0: addr_d   = writedata[6:0];
                4'd1: data_d   = writedata;
                4'd2: rw_d     = writedata[0];
                4'd3: if (writedata != '0) begin
                    state_d   = S_START;
                    fifo_clr  = 1'b1;
                    ack_err_d = 1'b0;
                end
                4'd4: nbytes_d = writedata[7:0];
                4'd5: begin
                    if (writedata[0]) ack_err_d = 1'b0;
                    if (writedata[1]) timeout_d = 1'b0;
                    if (writedata[2]) ovf_d     = 1'b0;
                end
                4'd7: if (writedata < 32'(NUM_CHANNELS)) chan_d = writedata[2:0];
                4'd8: ro_d = writedata[0];
                4'd9: begin
                    state_d    = S_RECOVER;
                    half_cnt_d = '0;
                    half_idx_d = '0;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_START: begin
                wd_d    = WD_LOAD;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (m_ack_error) ack_err_d = 1'b1;
                if (m_byte_counter >= nbytes_q) begin
                    state_d = S_DRAIN;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == 32'd1)) begin
                    state_d    = S_RECOVER;
                    timeout_d  = 1'b1;
                    half_cnt_d = '0;
                    half_idx_d = '0;
                end else if (wd_q != '0) begin
                    wd_d = wd_q - 32'd1;
                end
            end
            S_DRAIN: begin
                if (m_ack_error) ack_err_d = 1'b1;
                if (!m_busy) state_d = S_IDLE;
            end
            S_RECOVER: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (half_idx_q == IDX_LAST) state_d = S_IDLE;
                    else half_idx_d = half_idx_q + 8'd1;
                end else begin
                    half_cnt_d = half_cnt_q + 16'd1;
                end
            end
            default: ;
        endcase

        // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
        if (fifo_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            fifo_we = push && (!full || pop);
            if (push && !fifo_we) ovf_d = 1'b1;
            if (fifo_we) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (fifo_we && !pop)      usedw_d = usedw_q + 1'b1;
            else if (!fifo_we && pop) usedw_d = usedw_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE; addr_q    <= '0;  data_q    <= '0;
            rw_q       <= 1'b0;   ro_q      <= 1'b0; nbytes_q <= '0;
            chan_q     <= '0;     ack_err_q <= 1'b0; timeout_q <= 1'b0;
            ovf_q      <= 1'b0;   wd_q      <= '0;
            half_cnt_q <= '0;     half_idx_q <= '0;
            wr_ptr_q   <= '0;     rd_ptr_q  <= '0;  usedw_q   <= '0;
            fack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;    addr_q     <= addr_d;     data_q    <= data_d;
            rw_q       <= rw_d;       ro_q       <= ro_d;       nbytes_q  <= nbytes_d;
            chan_q     <= chan_d;     ack_err_q  <= ack_err_d;  timeout_q <= timeout_d;
            ovf_q      <= ovf_d;      wd_q       <= wd_d;
            half_cnt_q <= half_cnt_d; half_idx_q <= half_idx_d;
            wr_ptr_q   <= wr_ptr_d;   rd_ptr_q   <= rd_ptr_d;   usedw_q   <= usedw_d;
            fack_q     <= m_fifo_write_ack;
        end
    end

    // NOTE: FIFO storage has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clock) begin
        if (fifo_we) mem[wr_ptr_q] <= m_data_rd;
    end

    // Recovery: SCL low one half, pulses on odd halves, then a STOP built from SDA low and release.
    assign rec_scl_low = (half_idx_q == 8'd0) || (half_idx_q == IDX_STOP) ||
                         ((half_idx_q <= IDX_PULSE) && !half_idx_q[0]);
    assign rec_sda_low = (half_idx_q == IDX_STOP) || (half_idx_q == IDX_STOP + 8'd1);
    assign core_owns   = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign drv_scl_low = (state_q == S_RECOVER) ? rec_scl_low : (core_owns && m_scl_low);
    assign drv_sda_low = (state_q == S_RECOVER) ? rec_sda_low : (core_owns && m_sda_low);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pad
        assign scl[g] = ((chan_q == 3'(g)) && drv_scl_low) ? 1'b0 : 1'bz;
        assign sda[g] = ((chan_q == 3'(g)) && drv_sda_low) ? 1'b0 : 1'bz;
    end

    always_comb begin
        m_scl_in = 1'b1;
        m_sda_in = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (chan_q == 3'(i)) begin
                m_scl_in = scl[i];
                m_sda_in = sda[i];
            end
        end
    end

    always_comb begin
        case (address)
            4'd0:    readdata = {25'd0, addr_q};
            4'd1:    readdata = mem[rd_ptr_q];
            4'd2:    readdata = {31'd0, rw_q};
            4'd3:    readdata = {31'd0, state_q != S_IDLE};
            4'd4:    readdata = {31'd0, m_busy};
            4'd5:    readdata = {29'd0, ovf_q, timeout_q, ack_err_q};
            4'd6:    readdata = 32'(usedw_q);
            4'd7:    readdata = {29'd0, chan_q};
            4'd8:    readdata = {31'd0, ro_q};
            4'd9:    readdata = {31'd0, state_q == S_RECOVER};
            default: readdata = 32'hDEAD_BEEF;
        endcase
    end

    assign waitrequest       = write && (state_q != S_IDLE);
    assign m_ena             = (state_q == S_START) || (state_q == S_RUN);
    assign m_addr            = addr_q;
    assign m_rw              = rw_q;
    assign m_data_wr         = data_q;
    assign m_read_only       = ro_q;
    assign m_number_of_bytes = nbytes_q;
endmodule
